// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues req/ack word reads and buffers
// fetched words for the control unit. FETCH_PREFETCH_EN enables a DEPTH-entry prefetch buffer.
module fetch_stage #(
    parameter int          DEPTH    = 2,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        pc_sel,
    input  logic [15:0] jump_target,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [15:0] instr,
    output logic [3:0]  op,
    output logic [15:0] instr_pc
);

`ifdef FETCH_PREFETCH_EN
    localparam int BUF_D = (DEPTH < 1) ? 1 : DEPTH;
`else
    // Single instruction register; DEPTH has no effect in this build.
    localparam int BUF_D = (DEPTH > 1) ? 1 : 1;
`endif

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [15:0]      pc_q, pc_d;
    logic [15:0]      addr_q, addr_d;
    logic             req_q, req_d;
    logic [15:0]      ins_q [BUF_D];
    logic [15:0]      ins_d [BUF_D];
    logic [15:0]      ipc_q [BUF_D];
    logic [15:0]      ipc_d [BUF_D];
    logic [BUF_D-1:0] vld_q, vld_d;
    logic             push, pop, full, placed;

    // Entry 0 is always the head, so the consumer-facing outputs come straight from flops.
    assign pop  = vld_q[0] && instr_ready;
    assign full = vld_q[BUF_D-1];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        req_d   = req_q;
        push    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (en && !full && !pc_sel) begin
                    state_d = S_FETCH;
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                end
            end
            S_FETCH: begin
                if (imem_ack) begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                    push    = !pc_sel;
                    pc_d    = pc_q + 16'd1;
                end else if (pc_sel) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Old request stays on the bus until the memory completes it.
                if (imem_ack) begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase
        if (pc_sel) begin
            pc_d = jump_target;
        end
    end

    always_comb begin
        ins_d  = ins_q;
        ipc_d  = ipc_q;
        vld_d  = vld_q;
        placed = 1'b0;
        if (pop) begin
            for (int i = 0; i < BUF_D - 1; i++) begin
                ins_d[i] = ins_q[i+1];
                ipc_d[i] = ipc_q[i+1];
                vld_d[i] = vld_q[i+1];
            end
            vld_d[BUF_D-1] = 1'b0;
        end
        if (push) begin
            for (int i = 0; i < BUF_D; i++) begin
                if (!placed && !vld_d[i]) begin
                    ins_d[i] = imem_rdata;
                    ipc_d[i] = addr_q;
                    vld_d[i] = 1'b1;
                    placed   = 1'b1;
                end
            end
        end
        if (pc_sel) begin
            vld_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            req_q   <= 1'b0;
            vld_q   <= '0;
            for (int i = 0; i < BUF_D; i++) begin
                ins_q[i] <= '0;
                ipc_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            vld_q   <= vld_d;
            for (int i = 0; i < BUF_D; i++) begin
                ins_q[i] <= ins_d[i];
                ipc_q[i] <= ipc_d[i];
            end
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr_valid = vld_q[0];
    assign instr       = ins_q[0];
    assign op          = ins_q[0][15:12];
    assign instr_pc    = ipc_q[0];

endmodule
